mult_shift_add: RTL and testbench



---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_shift_add_if.sv | 29 ++
 rtl/add_sub_33.sv | 19 +
 rtl/and_32_bits.sv | 18 +
 rtl/mult_shift_add.sv | 116 +++++++++++
 tb/tb_mult_shift_add.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared widths, FSM encodings and helpers for the iterative
//            shift-and-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The product overflows signed WIDTH bits when its upper half is not a
  // pure sign extension of the lower half.
  function automatic logic prod_overflow(input logic [2*WIDTH-1:0] p);
    return (p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}});
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_shift_add_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add_if
// Brief    : Operand / start / result bundle between the multdiv control
//            and the multiplier datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_shift_add_if;
  import mult_pkg::*;

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT,
    output data_result, data_exception, data_resultRDY
  );

endinterface
`default_nettype wire

// File: rtl/add_sub_33.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_33
// Brief    : 33-bit adder/subtractor; sub=1 computes a - b. Carry-out is
//            dropped, the result wraps modulo 2^33.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum
);

  // Two's-complement subtract: invert b and inject the +1 as carry-in.
  assign sum = a + (b ^ {33{sub}}) + {32'd0, sub};

endmodule
`default_nettype wire

// File: rtl/and_32_bits.sv
`default_nettype none
// ============================================================================
// Module   : and_32_bits
// Brief    : 32-bit bitwise AND gate array.
// Revision : 1.0 - initial release
// ============================================================================
module and_32_bits (
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic [31:0] data_out
);

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign data_out[i] = data_a[i] & data_b[i];
  end

endmodule
`default_nettype wire

// File: rtl/mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add
// Brief    : Iterative signed 32x32 shift-and-add multiplier. One partial
//            product per cycle, 33-bit accumulator, subtract on the final
//            iteration to weight the multiplier sign bit negatively.
// Revision : 1.0 - initial release
// ============================================================================
module mult_shift_add
  import mult_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  mult_shift_add_if.slave bus
);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH:0]     r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_result;
  logic               r_exception;
  logic               r_rdy;

  logic [WIDTH-1:0]   w_pp;
  logic [WIDTH:0]     w_sum;
  logic               w_last;
  logic               w_iter;
  logic               w_done;
  logic [2*WIDTH-1:0] w_product;

  assign w_last    = (r_count == LAST_ITER);
  assign w_product = {r_hi[WIDTH-1:0], r_lo};

  // Multiplicand gated by the multiplier bit currently at lo[0].
  and_32_bits u_pp (
    .data_a   (r_a),
    .data_b   ({WIDTH{r_lo[0]}}),
    .data_out (w_pp)
  );

  // Accumulate the sign-extended partial product; subtract on the last step.
  add_sub_33 u_acc (
    .a   (r_hi),
    .b   ({w_pp[WIDTH-1], w_pp}),
    .sub (w_last),
    .sum (w_sum)
  );

  // Next-state decode; a start pulse in any state (re)starts the sequence.
  always_comb begin
    w_next_state = r_state;
    w_iter       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ctrl_MULT) w_next_state = BUSY;
      end
      BUSY: begin
        if (!bus.ctrl_MULT) begin
          w_iter = 1'b1;
          if (w_last) w_next_state = DONE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_next_state = bus.ctrl_MULT ? BUSY : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Operand latch, shift/accumulate iteration, counter and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_a         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= w_done;
      if (w_done) begin
        r_result    <= w_product[WIDTH-1:0];
        r_exception <= prod_overflow(w_product);
      end
      if (bus.ctrl_MULT) begin
        r_a     <= bus.data_operandA;
        r_hi    <= '0;
        r_lo    <= bus.data_operandB;
        r_count <= '0;
      end else if (w_iter) begin
        // Arithmetic shift right of {sum, lo}: sum[32] is replicated.
        r_hi    <= {w_sum[WIDTH], w_sum[WIDTH:1]};
        r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_shift_add
// Brief    : Directed self-checking bench for mult_shift_add.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_shift_add;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  mult_shift_add_if bus ();

  mult_shift_add dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a one-cycle start pulse; returns just after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
  endtask

  // Cycles until the ready pulse, -1 if none within the bound.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.ctrl_MULT = 1'b0;
    repeat (2) @(negedge clock);
    n_tests++;
    if (bus.data_result !== 32'd0) begin
      n_fail++; $display("FAIL reset_result: got %h expected %h", bus.data_result, 32'd0);
    end
    n_tests++;
    if (bus.data_exception !== 1'b0) begin
      n_fail++; $display("FAIL reset_exception: got %b expected 0", bus.data_exception);
    end
    n_tests++;
    if (bus.data_resultRDY !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_exc,
                           input string name);
    int lat;
    start_op(a, b);
    wait_rdy(lat);
    n_tests++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL %s latency: got %0d expected 33", name, lat);
    end
    n_tests++;
    if (bus.data_result !== exp_res) begin
      n_fail++; $display("FAIL %s result: got %h expected %h", name, bus.data_result, exp_res);
    end
    n_tests++;
    if (bus.data_exception !== exp_exc) begin
      n_fail++; $display("FAIL %s exception: got %b expected %b", name, bus.data_exception, exp_exc);
    end
    @(negedge clock);
    n_tests++;
    if (bus.data_resultRDY !== 1'b0) begin
      n_fail++; $display("FAIL %s rdy_pulse_width: got %b expected 0", name, bus.data_resultRDY);
    end
    n_tests++;
    if (bus.data_result !== exp_res) begin
      n_fail++; $display("FAIL %s result_hold: got %h expected %h", name, bus.data_result, exp_res);
    end
  endtask

  task automatic test_vectors();
    test_mult(32'd3,          32'd5,          32'd15,         1'b0, "3x5");
    test_mult(32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6,   1'b0, "m7x6");
    test_mult(32'd6,          32'hFFFFFFF9,   32'hFFFFFFD6,   1'b0, "6xm7");
    test_mult(32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE,   1'b1, "maxx2");
    test_mult(32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1, "minxm1");
    test_mult(32'h80000000,   32'd1,          32'h80000000,   1'b0, "minx1");
    test_mult(32'd0,          32'hFFFFFFFF,   32'd0,          1'b0, "0xm1");
    test_mult(32'h80000000,   32'h80000000,   32'd0,          1'b1, "minxmin");
    test_mult(32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, "m1xm1");
    test_mult(32'h00010000,   32'h00010000,   32'd0,          1'b1, "2p16sq");
  endtask

  // Back-to-back: a start the cycle right after the ready pulse is accepted.
  task automatic test_back_to_back();
    int lat;
    start_op(32'd12, 32'd11);
    wait_rdy(lat);
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'hFFFFFFFD;
    bus.ctrl_MULT     = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    wait_rdy(lat);
    n_tests++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL b2b latency: got %0d expected 33", lat);
    end
    n_tests++;
    if (bus.data_result !== 32'hFFFFFFE5) begin
      n_fail++; $display("FAIL b2b result: got %h expected %h", bus.data_result, 32'hFFFFFFE5);
    end
  endtask

  task automatic test_abort_busy();
    int lat;
    int seen;
    seen = 0;
    start_op(32'd3, 32'd5);
    repeat (8) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) seen++;
    end
    start_op(32'd4, 32'd4);
    wait_rdy(lat);
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort_busy early_rdy: got %0d expected 0", seen);
    end
    n_tests++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL abort_busy latency: got %0d expected 33", lat);
    end
    n_tests++;
    if (bus.data_result !== 32'd16) begin
      n_fail++; $display("FAIL abort_busy result: got %h expected %h", bus.data_result, 32'd16);
    end
  endtask

  // Start in the DONE cycle: completed result still reported, then restart.
  task automatic test_abort_done();
    int lat;
    int seen;
    seen = 0;
    start_op(32'd7, 32'd3);
    repeat (32) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) seen++;
    end
    bus.data_operandA = 32'd5;
    bus.data_operandB = 32'd5;
    bus.ctrl_MULT     = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort_done early_rdy: got %0d expected 0", seen);
    end
    n_tests++;
    if (bus.data_resultRDY !== 1'b1) begin
      n_fail++; $display("FAIL abort_done rdy: got %b expected 1", bus.data_resultRDY);
    end
    n_tests++;
    if (bus.data_result !== 32'd21) begin
      n_fail++; $display("FAIL abort_done first_result: got %h expected %h", bus.data_result, 32'd21);
    end
    wait_rdy(lat);
    n_tests++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL abort_done latency: got %0d expected 33", lat);
    end
    n_tests++;
    if (bus.data_result !== 32'd25) begin
      n_fail++; $display("FAIL abort_done second_result: got %h expected %h", bus.data_result, 32'd25);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    start_op(32'd3, 32'd5);
    repeat (11) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if (bus.data_result !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid result: got %h expected %h", bus.data_result, 32'd0);
    end
    n_tests++;
    if (bus.data_exception !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid exception: got %b expected 0", bus.data_exception);
    end
    // Reset must win over a simultaneous start.
    bus.data_operandA = 32'd8;
    bus.data_operandB = 32'd8;
    bus.ctrl_MULT     = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    reset             = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_mid spurious_rdy: got %0d expected 0", seen);
    end
    test_mult(32'd2, 32'd9, 32'd18, 1'b0, "after_reset_2x9");
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    reset             = 1'b1;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_abort_busy();
    test_abort_done();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
